// File: rtl/sal_ddr_pkg.sv
// ---------------------------------------------------------------------------------------------
// sal_ddr_pkg
// Purpose : shared types and constants for the DDR controller refresh path.
// Contents: ref_state_t     refresh sequencer states
//           MAX_POSTPONE_JEDEC  JEDEC limit on postponed auto-refreshes
//           pend_w()        width needed to hold a pending count of 0..max_pp
// ---------------------------------------------------------------------------------------------
package sal_ddr_pkg;

  localparam int unsigned MAX_POSTPONE_JEDEC = 8;

  typedef enum logic [1:0] {
    REF_IDLE  = 2'd0,
    REF_REQ   = 2'd1,
    REF_ISSUE = 2'd2,
    REF_RFC   = 2'd3
  } ref_state_t;

  function automatic int unsigned pend_w(input int unsigned max_pp);
    return $clog2(max_pp + 1);
  endfunction

endpackage

// File: rtl/sal_refresh_sched_if.sv
// ---------------------------------------------------------------------------------------------
// sal_refresh_sched_if
// Purpose : REF command handshake between the refresh scheduler and the command bus.
// Signals : ref_cmd_valid  scheduler -> bus   REF command request
//           ref_cmd_ready  bus -> scheduler   bus accepts REF
//           ref_busy       scheduler -> bus   tRFC window active, no ACT permitted
// Modports: master = refresh scheduler, slave = command scheduler
// ---------------------------------------------------------------------------------------------
interface sal_refresh_sched_if;

  logic ref_cmd_valid;
  logic ref_cmd_ready;
  logic ref_busy;

  modport master (
    output ref_cmd_valid,
    output ref_busy,
    input  ref_cmd_ready
  );

  modport slave (
    input  ref_cmd_valid,
    input  ref_busy,
    output ref_cmd_ready
  );

endinterface

// File: rtl/sal_refi_timer.sv
// ---------------------------------------------------------------------------------------------
// sal_refi_timer
// Purpose : tREFI reload down-counter. Emits a registered one-cycle tick every i_reload+1
//           cycles while enabled; held at the reload value while disabled.
// Ports   : clk, rst_n  clock, asynchronous active-low reset
//           i_en        tick generation enable
//           i_reload    tREFI-1, sampled at every reload
//           o_tick      one-cycle refresh-interval tick
// ---------------------------------------------------------------------------------------------
module sal_refi_timer #(
  parameter int unsigned REFI_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [REFI_W-1:0] i_reload,
  output logic              o_tick
);

  logic [REFI_W-1:0] r_cnt;
  logic              r_tick;
  logic              w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_tick = r_tick;

  // Counter resets to 0 so the first tick follows one cycle after enable rises out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= i_en & w_zero;
      if (!i_en || w_zero) begin
        r_cnt <= i_reload;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_refresh_sched.sv
// ---------------------------------------------------------------------------------------------
// sal_refresh_sched
// Purpose : auto-refresh scheduler. Counts tREFI ticks into a postponed-refresh backlog,
//           requests all-bank quiescence, issues one REF per pass and blocks ACT for tRFC.
// Ports   : clk, rst_n       clock, asynchronous active-low reset
//           i_ref_en         refresh tick generation enable
//           i_t_refi_m1      tREFI-1 (sampled on counter reload)
//           i_t_rfc_m1       tRFC-1 (sampled on REF handshake)
//           i_sched_idle     no queued RD/WR, refresh may go early
//           i_bank_idle      per-bank precharged and timers expired
//           cmd_if           REF valid/ready handshake and tRFC busy (master side)
//           o_ref_req        banks must precharge and stop ACT
//           o_ref_urgent     backlog at or above the urgent threshold
//           o_pend_cnt       outstanding refreshes
//           o_err_ovf        sticky: tick arrived with a full backlog
// ---------------------------------------------------------------------------------------------
module sal_refresh_sched
  import sal_ddr_pkg::*;
#(
  parameter  int unsigned NUM_BANK     = 4,
  parameter  int unsigned REFI_W       = 16,
  parameter  int unsigned RFC_W        = 8,
  parameter  int unsigned MAX_POSTPONE = MAX_POSTPONE_JEDEC,
  parameter  int unsigned URGENT_TH    = 6,
  localparam int unsigned PEND_W       = pend_w(MAX_POSTPONE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_ref_en,
  input  logic [REFI_W-1:0]          i_t_refi_m1,
  input  logic [RFC_W-1:0]           i_t_rfc_m1,
  input  logic                       i_sched_idle,
  input  logic [NUM_BANK-1:0]        i_bank_idle,
  sal_refresh_sched_if.master        cmd_if,
  output logic                       o_ref_req,
  output logic                       o_ref_urgent,
  output logic [PEND_W-1:0]          o_pend_cnt,
  output logic                       o_err_ovf
);

  ref_state_t        r_state;
  logic [RFC_W-1:0]  r_rfc_cnt;
  logic [PEND_W-1:0] r_pend;
  logic              r_err;
  logic              r_req;
  logic              r_valid;
  logic              r_busy;

  logic w_tick;
  logic w_hs;
  logic w_urgent;
  logic w_pend_full;

  sal_refi_timer #(
    .REFI_W (REFI_W)
  ) u_refi_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (i_ref_en),
    .i_reload (i_t_refi_m1),
    .o_tick   (w_tick)
  );

  assign w_hs        = r_valid & cmd_if.ref_cmd_ready;
  assign w_urgent    = (r_pend >= PEND_W'(URGENT_TH));
  assign w_pend_full = (r_pend == PEND_W'(MAX_POSTPONE));

  // Backlog: a tick and a handshake in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else if (w_tick && !w_hs) begin
      if (w_pend_full) begin
        r_err <= 1'b1;
      end else begin
        r_pend <= r_pend + 1'b1;
      end
    end else if (w_hs && !w_tick) begin
      r_pend <= r_pend - 1'b1;
    end
  end

  // Sequencer. Outputs are registered alongside the state so nothing is combinational from
  // ref_cmd_ready. i_ref_en is deliberately not consulted: the backlog drains regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= REF_IDLE;
      r_rfc_cnt <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        REF_IDLE: begin
          if ((r_pend != '0) && (w_urgent || i_sched_idle)) begin
            r_state <= REF_REQ;
            r_req   <= 1'b1;
          end
        end
        REF_REQ: begin
          if (&i_bank_idle) begin
            r_state <= REF_ISSUE;
            r_valid <= 1'b1;
          end
        end
        REF_ISSUE: begin
          if (cmd_if.ref_cmd_ready) begin
            r_state   <= REF_RFC;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_busy    <= 1'b1;
            r_rfc_cnt <= i_t_rfc_m1;
          end
        end
        REF_RFC: begin
          if (r_rfc_cnt == '0) begin
            r_state <= REF_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rfc_cnt <= r_rfc_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_if.ref_cmd_valid = r_valid;
  assign cmd_if.ref_busy      = r_busy;
  assign o_ref_req            = r_req;
  assign o_ref_urgent         = w_urgent;
  assign o_pend_cnt           = r_pend;
  assign o_err_ovf            = r_err;

endmodule
